uart_imem_loader: RTL
=====================

Name: uart_imem_loader

Overview:
- Boot-time program loader. Receives a program image over an 8N1 UART line and drives the instruction-memory write port, which is otherwise tied off.
- Holds the CPU in reset (cpu_hold) until the whole image is written.
- Runs on the undivided board clock and sits beside power_on_reset in the top level.
- imem write port is the writer end of the same interface the CPU reads through.

Parameters:
- CLKS_PER_BIT, 434, board clocks per UART bit (50 MHz / 115200); minimum 4.
- MAX_WORDS, 1024, largest accepted word count; larger headers are clamped to this value.

Ports:
- clk  input  1  board clock.
- resetn  input  1  asynchronous active-low reset.
- rx  input  1  UART receive line, asynchronous, idle high.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  32  byte address of the word being written; always word aligned.
- imem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  high while loading; top level ORs it into the CPU reset.
- load_done  output  1  high once the image has been completely written.
- frame_err  output  1  sticky; set by any stop bit sampled low.

Behaviour:
- Reset (resetn low, asynchronous): imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, frame_err=0. Receiver returns to RX_IDLE and loader to L_CNT_LO.
- rx passes through a 2-FF synchronizer, which is preset to 1 on reset. All rx timing below refers to the synchronized signal.
- Receiver FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a high-to-low edge starts a bit counter and moves to RX_START.
  - RX_START: samples at CLKS_PER_BIT/2 (integer division). A high sample is a glitch: return to RX_IDLE with no byte produced. A low sample moves to RX_DATA.
  - RX_DATA: 8 samples, CLKS_PER_BIT apart, LSB first.
  - RX_STOP: one sample CLKS_PER_BIT later. High gives a one-cycle byte_valid pulse. Low sets frame_err and produces no byte.
- Loader FSM: L_CNT_LO -> L_CNT_HI -> L_DATA -> L_DONE.
  - Header is a 16-bit little-endian word count N, clamped to MAX_WORDS.
  - N=0: go from L_CNT_HI straight to L_DONE.
  - L_DATA packs bytes little-endian: byte0 goes to [7:0], byte3 to [31:24].
  - On the 4th byte_valid: the next cycle drives imem_we=1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = 4*k, where k is the zero-based word index.
  - imem_addr advances by 4 in the cycle after the strobe and holds otherwise.
  - After the N-th write, enter L_DONE in the same cycle the strobe deasserts.
- L_DONE: load_done=1 and cpu_hold=0 from that cycle on. All further UART traffic is ignored. Leaving L_DONE requires reset.
- Frame error in L_CNT_LO, L_CNT_HI or L_DATA:
  - Abort the load; return to L_CNT_LO.
  - imem_addr returns to 0 and the partial word is discarded.
  - cpu_hold stays 1.
  - frame_err stays set until reset.
  - Words already written are not erased.
- Simultaneous events:
  - A byte_valid cannot coincide with an imem_we strobe, because the next byte is at least 9 bit-times away.
  - A reset asserted mid-byte or mid-write drops imem_we immediately, with no partial strobe.
- imem_addr wraps modulo 2^32. This is unreachable within the MAX_WORDS clamp.

Test Plan:
- Reset, rx held high for 10 bit-times -> imem_we never pulses; cpu_hold=1, load_done=0, frame_err=0.
- CLKS_PER_BIT=8; send 02 00, then 13 05 00 00, then 93 05 15 00:
  - imem_we pulses twice.
  - First write: addr 0x0, data 0x00000513. Second write: addr 0x4, data 0x00150593.
  - load_done=1 and cpu_hold=0 in the cycle after the second strobe.
- Header 00 00 -> load_done=1 with no imem_we pulse. Bytes sent afterwards cause no writes.
- Low glitch on rx shorter than CLKS_PER_BIT/2 while idle -> no byte accepted; the following valid header still loads correctly.
- Mid-image frame with stop bit forced low -> frame_err=1, cpu_hold=1, loader back at L_CNT_LO. A fresh complete image then loads from address 0 and sets load_done; frame_err remains 1.
- resetn pulsed low in the middle of byte 2 of data word 1 -> all outputs return to reset values asynchronously. A full reload afterwards writes from address 0.

Source files
------------

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART and writes it into instruction memory.
// Holds the CPU in reset until the image is complete; a stop-bit error aborts the load and restarts header parsing.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAXW    = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_DONE} ld_state_t;

  rx_state_t rx_state, rx_next;
  ld_state_t ld_state, ld_next;

  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          sample_pt, byte_vld, stop_err, abort;

  logic [7:0]    cnt_lo;
  logic [16:0]   hdr_cnt, hdr_clamped, words_left;
  logic [1:0]    byte_idx;
  logic [23:0]   word_acc;

  // rx_prev is one more stage so the falling edge is seen on synchronized data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next   = rx_state;
    byte_vld  = 1'b0;
    stop_err  = 1'b0;
    sample_pt = (rx_state == RX_START) ? (bit_cnt == HALF_M1) : (bit_cnt == FULL_M1);
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (sample_pt) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample_pt && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (sample_pt) begin
          rx_next  = RX_IDLE;
          byte_vld = rx_sync;
          stop_err = !rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || sample_pt) bit_cnt <= '0;
      else                                  bit_cnt <= bit_cnt + CW'(1);
      if (rx_state == RX_START) begin
        bit_idx <= '0;
      end else if (rx_state == RX_DATA && sample_pt) begin
        bit_idx  <= bit_idx + 3'd1;
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
      if (stop_err) frame_err <= 1'b1;
    end
  end

  // Once loaded, line errors no longer matter: only reset leaves L_DONE.
  assign abort       = stop_err && (ld_state != L_DONE);
  assign hdr_cnt     = {1'b0, rx_shift, cnt_lo};
  assign hdr_clamped = (hdr_cnt > MAXW) ? MAXW : hdr_cnt;
  assign load_done   = (ld_state == L_DONE);
  assign cpu_hold    = !load_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ld_state <= L_CNT_LO;
    else         ld_state <= ld_next;
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_CNT_LO: if (byte_vld) ld_next = L_CNT_HI;
      L_CNT_HI: if (byte_vld) ld_next = (hdr_clamped == 17'd0) ? L_DONE : L_DATA;
      L_DATA:   if (imem_we && words_left == 17'd1) ld_next = L_DONE;
      default:  ld_next = L_DONE;
    endcase
    if (abort) ld_next = L_CNT_LO;
  end

  // A byte and a write strobe never coincide: bytes are at least 9 bit-times apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cnt_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_acc   <= '0;
    end else begin
      imem_we <= byte_vld && (ld_state == L_DATA) && (byte_idx == 2'd3);
      if (abort) begin
        imem_addr <= '0;
        byte_idx  <= '0;
      end else begin
        if (imem_we) begin
          imem_addr  <= imem_addr + 32'd4;
          words_left <= words_left - 17'd1;
        end
        if (byte_vld) begin
          case (ld_state)
            L_CNT_LO: cnt_lo <= rx_shift;
            L_CNT_HI: begin
              words_left <= hdr_clamped;
              imem_addr  <= '0;
              byte_idx   <= '0;
            end
            L_DATA: begin
              byte_idx <= byte_idx + 2'd1;
              word_acc <= {rx_shift, word_acc[23:8]};
              if (byte_idx == 2'd3) imem_wdata <= {rx_shift, word_acc};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
